main_memory_controller: RTL and testbench
=========================================

MAIN_MEMORY_CONTROLLER -- requirements
Module: main_memory_controller

Interface
REQ-001 SHALL have parameter ADRES_BIT, default 32, meaning byte address width.
REQ-002 SHALL have parameter VERI_BIT, default 32, meaning main-memory word width.
REQ-003 SHALL have parameter BLOK_BIT, default 128, meaning cache block width (4 words).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port anabellek_denetleyici_okuma_istek_adres_i  input  ADRES_BIT  block read address from the instruction cache controller.
REQ-007 SHALL have port anabellek_denetleyici_okuma_istek_gecerli_i  input  1  block read request valid.
REQ-008 SHALL have port anabellek_denetleyici_okuma_veri_blok_o  output  BLOK_BIT  assembled block; word i in bits [32i+31:32i].
REQ-009 SHALL have port anabellek_denetleyici_okuma_istek_hazir_o  output  1  block complete, one-cycle pulse.
REQ-010 SHALL have port bellek_istek_adres_o  output  ADRES_BIT  word address to main memory.
REQ-011 SHALL have port bellek_istek_gecerli_o  output  1  word read request valid.
REQ-012 SHALL have port bellek_istek_hazir_i  input  1  main memory accepts the request this cycle.
REQ-013 SHALL have port bellek_yanit_veri_i  input  VERI_BIT  returned word.
REQ-014 SHALL have port bellek_yanit_gecerli_i  input  1  returned word valid.

Function
REQ-015 SHALL implement states BOSTA, ISTEK, YANIT, TAMAM.
REQ-016 BOSTA: SHALL sample gecerli_i; if 1, register adres_i[31:4] as block base, set beat counter to the start beat, go to ISTEK.
REQ-017 ISTEK: SHALL drive bellek_istek_gecerli_o=1 and bellek_istek_adres_o={base, beat[1:0], 2'b00}; move to YANIT on the cycle bellek_istek_hazir_i=1, else stay with address held stable.
REQ-018 YANIT: on bellek_yanit_gecerli_i=1 SHALL write bellek_yanit_veri_i into block word slot = beat; if 4 words collected go to TAMAM, else increment beat modulo 4 and go to ISTEK.
REQ-019 TAMAM: SHALL drive anabellek_denetleyici_okuma_istek_hazir_o=1 for exactly this one cycle, then go to BOSTA.
REQ-020 At most one memory request SHALL be outstanding; bellek_istek_gecerli_o SHALL be 0 outside ISTEK.
REQ-021 bellek_yanit_gecerli_i outside YANIT SHALL be ignored.
REQ-022 gecerli_i outside BOSTA SHALL be ignored; a request still held high on return to BOSTA SHALL start a new fetch.
REQ-023 veri_blok_o SHALL be registered and held stable from TAMAM until the first word of the next fetch is written.
REQ-024 Minimum latency with zero-wait memory (hazir_i=1 in ISTEK, yanit one cycle later): accept at T, hazir_o at T+9.
REQ-025 Address bits [3:0] SHALL not affect block base; beat counter wraps 3->0 without carry into base.

Reset
REQ-026 rst_i=0 SHALL immediately force state BOSTA, veri_blok_o=0, hazir_o=0, bellek_istek_gecerli_o=0, bellek_istek_adres_o=0, beat counter=0, word count=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the fetch; a memory response arriving after reset release SHALL be ignored (REQ-021).

Configuration
REQ-028 Macro ANABELLEK_KRITIK_KELIME_EN defined: start beat SHALL be adres_i[3:2] (critical word first, wrapping order).
REQ-029 Macro ANABELLEK_KRITIK_KELIME_EN undefined: start beat SHALL be 0 (order 0,1,2,3); block slot placement identical in both builds.

Verification
REQ-030 Zero-wait fetch, adres_i=0x0000_1234, words 0x11,0x22,0x33,0x44 -> macro off: addresses 0x1230,0x1234,0x1238,0x123C; veri_blok_o=0x00000044_00000033_00000022_00000011; hazir_o pulse at T+9.
REQ-031 Same with macro on -> addresses 0x1234,0x1238,0x123C,0x1230; identical veri_blok_o.
REQ-032 bellek_istek_hazir_i held 0 for 3 cycles on beat 1 -> bellek_istek_adres_o stable those cycles, gecerli_o=1 throughout, hazir_o at T+12.
REQ-033 rst_i=0 during beat 2 YANIT, yanit_gecerli_i=1 after release -> state BOSTA, all outputs 0, no hazir_o pulse.
REQ-034 gecerli_i held 1 continuously, adres 0xFFFF_FFF0 -> addresses wrap within block 0xFFFF_FFF0..FC, back-to-back fetch starts at BOSTA cycle after TAMAM; spurious yanit_gecerli_i in ISTEK ignored.

Source files
------------

// File: rtl/main_memory_controller_if.sv
// Bus bundle between the instruction-cache controller, the block fetch controller
// and main memory. durum carries the controller's FSM state for observation.
interface main_memory_controller_if #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int BLOK_BIT  = 128
);
  // Cache side: the request is level-sensitive and is only sampled in BOSTA;
  // okuma_istek_hazir_o pulses for one cycle when veri_blok_o holds the full block.
  logic [ADRES_BIT-1:0] anabellek_denetleyici_okuma_istek_adres_i;
  logic                 anabellek_denetleyici_okuma_istek_gecerli_i;
  logic [BLOK_BIT-1:0]  anabellek_denetleyici_okuma_veri_blok_o;
  logic                 anabellek_denetleyici_okuma_istek_hazir_o;
  // Memory side: a request transfers on a cycle with gecerli_o && hazir_i;
  // exactly one response beat (yanit_gecerli_i) is expected per transfer.
  logic [ADRES_BIT-1:0] bellek_istek_adres_o;
  logic                 bellek_istek_gecerli_o;
  logic                 bellek_istek_hazir_i;
  logic [VERI_BIT-1:0]  bellek_yanit_veri_i;
  logic                 bellek_yanit_gecerli_i;
  logic [1:0]           durum;

  modport slave (
    input  anabellek_denetleyici_okuma_istek_adres_i,
    input  anabellek_denetleyici_okuma_istek_gecerli_i,
    output anabellek_denetleyici_okuma_veri_blok_o,
    output anabellek_denetleyici_okuma_istek_hazir_o,
    output bellek_istek_adres_o,
    output bellek_istek_gecerli_o,
    input  bellek_istek_hazir_i,
    input  bellek_yanit_veri_i,
    input  bellek_yanit_gecerli_i,
    output durum
  );

  modport master (
    output anabellek_denetleyici_okuma_istek_adres_i,
    output anabellek_denetleyici_okuma_istek_gecerli_i,
    input  anabellek_denetleyici_okuma_veri_blok_o,
    input  anabellek_denetleyici_okuma_istek_hazir_o,
    input  bellek_istek_adres_o,
    input  bellek_istek_gecerli_o,
    output bellek_istek_hazir_i,
    output bellek_yanit_veri_i,
    output bellek_yanit_gecerli_i,
    input  durum
  );
endinterface

// File: rtl/main_memory_controller.sv
// Fetches a 4-word cache block from main memory, one outstanding word request at a time.
// Define ANABELLEK_KRITIK_KELIME_EN to fetch the critical word first (wrapping order).
module main_memory_controller #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int BLOK_BIT  = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  main_memory_controller_if.slave       bus
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;
  localparam logic [1:0] TAMAM = 2'd3;

  logic [1:0]           state;
  logic [ADRES_BIT-5:0] base;
  logic [1:0]           beat;
  logic [1:0]           count;
  logic [BLOK_BIT-1:0]  blok;
  logic [1:0]           start_beat;

`ifdef ANABELLEK_KRITIK_KELIME_EN
  logic [1:0] unused_adres_low;
  assign start_beat       = bus.anabellek_denetleyici_okuma_istek_adres_i[3:2];
  assign unused_adres_low = bus.anabellek_denetleyici_okuma_istek_adres_i[1:0];
`else
  logic [3:0] unused_adres_low;
  assign start_beat       = 2'b00;
  assign unused_adres_low = bus.anabellek_denetleyici_okuma_istek_adres_i[3:0];
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= BOSTA;
      base  <= '0;
      beat  <= 2'b00;
      count <= 2'b00;
      blok  <= '0;
    end else begin
      case (state)
        BOSTA: begin
          if (bus.anabellek_denetleyici_okuma_istek_gecerli_i) begin
            base  <= bus.anabellek_denetleyici_okuma_istek_adres_i[ADRES_BIT-1:4];
            beat  <= start_beat;
            count <= 2'b00;
            state <= ISTEK;
          end
        end
        ISTEK: begin
          if (bus.bellek_istek_hazir_i) state <= YANIT;
        end
        YANIT: begin
          // Slot follows the beat, so the block layout is the same in either fetch order.
          if (bus.bellek_yanit_gecerli_i) begin
            blok[beat*VERI_BIT +: VERI_BIT] <= bus.bellek_yanit_veri_i;
            if (count == 2'd3) begin
              state <= TAMAM;
            end else begin
              count <= count + 2'd1;
              beat  <= beat + 2'd1;
              state <= ISTEK;
            end
          end
        end
        TAMAM:   state <= BOSTA;
        default: state <= BOSTA;
      endcase
    end
  end

  // Beat wraps inside its 2-bit field, so it never carries into the block base.
  assign bus.bellek_istek_adres_o                      = {base, beat, 2'b00};
  assign bus.bellek_istek_gecerli_o                    = (state == ISTEK);
  assign bus.anabellek_denetleyici_okuma_istek_hazir_o = (state == TAMAM);
  assign bus.anabellek_denetleyici_okuma_veri_blok_o   = blok;
  assign bus.durum                                     = state;

endmodule

// File: tb/tb_main_memory_controller.sv
// Scoreboard bench for main_memory_controller: directed fetches, a memory responder
// process and a monitor that checks request addresses, blocks and completion cycles.
module tb_main_memory_controller;

  logic clk;
  logic rst_n;

  main_memory_controller_if #(.ADRES_BIT(32), .VERI_BIT(32), .BLOK_BIT(128)) bus ();

  main_memory_controller #(.ADRES_BIT(32), .VERI_BIT(32), .BLOK_BIT(128)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors;
  int checks;
  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_blk_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] blk_words[4];
  int req_count;
  int resp_count;
  int resp_limit;
  int stall_at;
  int stall_cycles;
  bit force_resp;
  bit spurious;

  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    int          stalled;
    req_count  = 0;
    resp_count = 0;
    stalled    = 0;
    bus.bellek_istek_hazir_i   = 1'b1;
    bus.bellek_yanit_gecerli_i = 1'b0;
    bus.bellek_yanit_veri_i    = '0;
    forever begin
      @(negedge clk);
      acc      = bus.bellek_istek_gecerli_o && bus.bellek_istek_hazir_i && rst_n;
      acc_addr = bus.bellek_istek_adres_o;
      @(posedge clk);
      #1;
      if (acc) begin
        req_count++;
        stalled = 0;
      end
      bus.bellek_yanit_gecerli_i = 1'b0;
      bus.bellek_yanit_veri_i    = '0;
      if (acc && resp_count < resp_limit) begin
        bus.bellek_yanit_gecerli_i = 1'b1;
        bus.bellek_yanit_veri_i    = blk_words[acc_addr[3:2]];
        resp_count++;
      end else if (force_resp || (spurious && bus.bellek_istek_gecerli_o)) begin
        bus.bellek_yanit_gecerli_i = 1'b1;
        bus.bellek_yanit_veri_i    = 32'hdead_beef;
      end
      if (bus.bellek_istek_gecerli_o && req_count == stall_at && stalled < stall_cycles) begin
        bus.bellek_istek_hazir_i = 1'b0;
        stalled++;
      end else begin
        bus.bellek_istek_hazir_i = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.bellek_istek_gecerli_o) begin
          if (exp_addr_q.size() == 0) begin
            check("unexpected_mem_request", {96'd0, bus.bellek_istek_adres_o}, 128'hffff_ffff);
          end else begin
            check("mem_request_addr", {96'd0, bus.bellek_istek_adres_o}, {96'd0, exp_addr_q[0]});
            if (bus.bellek_istek_hazir_i) void'(exp_addr_q.pop_front());
          end
        end
        if (bus.anabellek_denetleyici_okuma_istek_hazir_o) begin
          if (exp_blk_q.size() == 0) begin
            check("unexpected_hazir_pulse", 128'd1, 128'd0);
          end else begin
            check("block_data", bus.anabellek_denetleyici_okuma_veri_blok_o, exp_blk_q.pop_front());
            check("hazir_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    blk_words[0] = w0;
    blk_words[1] = w1;
    blk_words[2] = w2;
    blk_words[3] = w3;
  endtask

  task automatic push_addrs(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
    exp_addr_q.push_back(a0);
    exp_addr_q.push_back(a1);
    exp_addr_q.push_back(a2);
    exp_addr_q.push_back(a3);
  endtask

  task automatic raise_req(input logic [31:0] addr, output int k);
    @(posedge clk);
    #1;
    bus.anabellek_denetleyici_okuma_istek_adres_i   = addr;
    bus.anabellek_denetleyici_okuma_istek_gecerli_i = 1'b1;
    k = cyc;
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    bus.anabellek_denetleyici_okuma_istek_gecerli_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_blk_q.size() != 0 || exp_addr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d blocks and %0d requests still pending, required 0",
               name, exp_blk_q.size(), exp_addr_q.size());
      exp_blk_q.delete();
      exp_addr_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_durum"},   {126'd0, bus.durum}, 128'd0);
    check({name, "_blok"},    bus.anabellek_denetleyici_okuma_veri_blok_o, 128'd0);
    check({name, "_hazir"},   {127'd0, bus.anabellek_denetleyici_okuma_istek_hazir_o}, 128'd0);
    check({name, "_gecerli"}, {127'd0, bus.bellek_istek_gecerli_o}, 128'd0);
    check({name, "_adres"},   {96'd0, bus.bellek_istek_adres_o}, 128'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k;
    int base_req;
    errors       = 0;
    checks       = 0;
    resp_limit   = 1000000;
    stall_at     = -1;
    stall_cycles = 0;
    force_resp   = 1'b0;
    spurious     = 1'b0;
    set_words(32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    bus.anabellek_denetleyici_okuma_istek_adres_i   = 32'h0000_1234;
    bus.anabellek_denetleyici_okuma_istek_gecerli_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    bus.anabellek_denetleyici_okuma_istek_gecerli_i = 1'b0;
    rst_n = 1'b1;

    // Zero-wait fetch of 0x1234.
    set_words(32'h11, 32'h22, 32'h33, 32'h44);
`ifdef ANABELLEK_KRITIK_KELIME_EN
    push_addrs(32'h1234, 32'h1238, 32'h123c, 32'h1230);
`else
    push_addrs(32'h1230, 32'h1234, 32'h1238, 32'h123c);
`endif
    raise_req(32'h0000_1234, k);
    exp_blk_q.push_back(128'h00000044_00000033_00000022_00000011);
    exp_cyc_q.push_back(k + 9);
    drop_req();
    wait_done("zero_wait");

    // Memory holds off the beat-1 request for three cycles.
    set_words(32'ha0a0_0000, 32'hb1b1_1111, 32'hc2c2_2222, 32'hd3d3_3333);
    stall_at     = req_count + 1;
    stall_cycles = 3;
`ifdef ANABELLEK_KRITIK_KELIME_EN
    push_addrs(32'h5678, 32'h567c, 32'h5670, 32'h5674);
`else
    push_addrs(32'h5670, 32'h5674, 32'h5678, 32'h567c);
`endif
    raise_req(32'h0000_5678, k);
    exp_blk_q.push_back(128'hd3d33333_c2c22222_b1b11111_a0a00000);
    exp_cyc_q.push_back(k + 12);
    drop_req();
    wait_done("stall");
    stall_at = -1;

    // Request held high: two back-to-back fetches at the top of the address space,
    // with junk responses driven while requests are pending.
    set_words(32'hcafe_0000, 32'hcafe_0001, 32'hcafe_0002, 32'hcafe_0003);
    spurious = 1'b1;
    push_addrs(32'hffff_fff0, 32'hffff_fff4, 32'hffff_fff8, 32'hffff_fffc);
    push_addrs(32'hffff_fff0, 32'hffff_fff4, 32'hffff_fff8, 32'hffff_fffc);
    raise_req(32'hffff_fff0, k);
    exp_blk_q.push_back(128'hcafe0003_cafe0002_cafe0001_cafe0000);
    exp_blk_q.push_back(128'hcafe0003_cafe0002_cafe0001_cafe0000);
    exp_cyc_q.push_back(k + 9);
    exp_cyc_q.push_back(k + 19);
    repeat (10) @(posedge clk);
    drop_req();
    wait_done("back_to_back");
    spurious = 1'b0;

    // Low address bits at the last word: beat order wraps without touching the base.
    set_words(32'h0102_0304, 32'h0506_0708, 32'h090a_0b0c, 32'h0d0e_0f10);
`ifdef ANABELLEK_KRITIK_KELIME_EN
    push_addrs(32'hffff_fffc, 32'hffff_fff0, 32'hffff_fff4, 32'hffff_fff8);
`else
    push_addrs(32'hffff_fff0, 32'hffff_fff4, 32'hffff_fff8, 32'hffff_fffc);
`endif
    raise_req(32'hffff_ffff, k);
    exp_blk_q.push_back(128'h0d0e0f10_090a0b0c_05060708_01020304);
    exp_cyc_q.push_back(k + 9);
    drop_req();
    wait_done("wrap");

    // Reset while waiting for the beat-2 response; late responses must be ignored.
    set_words(32'h7777_0000, 32'h7777_1111, 32'h7777_2222, 32'h7777_3333);
    base_req   = req_count;
    resp_limit = resp_count + 2;
    exp_addr_q.push_back(32'h2000);
    exp_addr_q.push_back(32'h2004);
    exp_addr_q.push_back(32'h2008);
    raise_req(32'h0000_2000, k);
    drop_req();
    for (int n = 0; n < 50 && req_count < base_req + 3; n++) @(negedge clk);
    check("reset_test_beat2_reached", 128'(req_count), 128'(base_req + 3));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_fetch_reset");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    force_resp = 1'b1;
    resp_limit = 1000000;
    repeat (2) @(posedge clk);
    #1;
    force_resp = 1'b0;
    repeat (12) @(negedge clk);
    check_idle("after_reset");
    check("reset_pending_requests", 128'(exp_addr_q.size()), 128'd0);

    // Normal operation resumes after the abandoned fetch.
    set_words(32'h5555_0000, 32'h5555_1111, 32'h5555_2222, 32'h5555_3333);
`ifdef ANABELLEK_KRITIK_KELIME_EN
    push_addrs(32'h1234, 32'h1238, 32'h123c, 32'h1230);
`else
    push_addrs(32'h1230, 32'h1234, 32'h1238, 32'h123c);
`endif
    raise_req(32'h0000_1234, k);
    exp_blk_q.push_back(128'h55553333_55552222_55551111_55550000);
    exp_cyc_q.push_back(k + 9);
    drop_req();
    wait_done("recover");
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
